// File: rtl/mode_req_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared constants and types for the clock/mode request front
//               end: mode encodings reported by the clock/mode controller,
//               exception code constants and the single-step FSM states.
// Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    // Mode encodings seen on mode_i
    localparam logic [3:0] MODE_ERR   = 4'd2;
    localparam logic [3:0] MODE_PAUSE = 4'd4;
    localparam logic [3:0] MODE_RUN   = 4'd5;
    localparam logic [3:0] MODE_UART  = 4'd6;

    // Exception code driven while nothing has been reported (reset value)
    localparam logic [3:0] EXC_NONE   = 4'd0;

    // Step sequencer gives up if RUN is not reached within this many cycles
    localparam logic [15:0] STEP_WAIT_LAST = 16'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GO   = 3'd1,
        ST_WAIT = 3'd2,
        ST_RUN  = 3'd3,
        ST_STOP = 3'd4
    } step_state_e;

endpackage
`default_nettype wire

// File: rtl/mode_req_sched_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, counter debouncer and registered
//               rising-edge detector for one raw board button.
//               The debounced level only changes after DEB_CYCLES
//               consecutive synchronised samples disagree with it.
// Ports       : clk_i   - clock
//               rst_i   - synchronous active-high reset
//               raw_i   - asynchronous raw button level
//               press_o - one-cycle pulse on each debounced press
// Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 100000   // legal range: 2 and above
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic press_o
);

    localparam int c_cnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_dly;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_level     <= 1'b0;
            r_level_dly <= 1'b0;
            r_press     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_sync1     <= raw_i;
            r_sync2     <= r_sync1;
            r_level_dly <= r_level;
            // Edge detector is itself a register stage
            r_press     <= r_level & ~r_level_dly;
            if (r_sync2 != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end else begin
                // Any agreeing sample restarts the stability window
                r_cnt <= '0;
            end
        end
    end

    assign press_o = r_press;

endmodule
`default_nettype wire

// File: rtl/mode_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : mode_req_sched
// Description : Front-end scheduler for the CPU clock/mode controller.
//               Debounces six raw buttons, arbitrates simultaneous presses
//               (uart > rst > err > pause > continue > step), and runs a
//               hardware single-step sequence PAUSE -> RUN(N) -> PAUSE.
// Ports       : clk_i, rst_i           - clock, synchronous active-high reset
//               btn_*_raw_i            - raw asynchronous buttons
//               mode_i                 - current controller mode
//               exc_code_i             - datapath exception code
//               btn_*_o                - one-cycle request pulses
//               exc_code_o             - exc_code_i delayed one cycle
//               step_busy_o            - single-step sequence in progress
// Revision    : 1.0  initial release
// ============================================================================
module mode_req_sched
    import ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 100000,
    parameter int STEP_CYCLES = 1        // legal range 1..65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_rst_raw_i,
    input  logic       btn_err_raw_i,
    input  logic       btn_pause_raw_i,
    input  logic       btn_continue_raw_i,
    input  logic       btn_uart_raw_i,
    input  logic       btn_step_raw_i,
    input  logic [3:0] mode_i,
    input  logic [3:0] exc_code_i,
    output logic       btn_rst_o,
    output logic       btn_err_o,
    output logic       btn_pause_o,
    output logic       btn_continue_o,
    output logic       btn_uart_o,
    output logic [3:0] exc_code_o,
    output logic       step_busy_o
);

    localparam logic [15:0] c_step_last = 16'(STEP_CYCLES - 1);

    logic w_ev_rst, w_ev_err, w_ev_pause, w_ev_cont, w_ev_uart, w_ev_step;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst   (.clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_rst_raw_i),      .press_o(w_ev_rst));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_err   (.clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_err_raw_i),      .press_o(w_ev_err));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (.clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_pause_raw_i),    .press_o(w_ev_pause));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cont  (.clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_continue_raw_i), .press_o(w_ev_cont));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_uart  (.clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_uart_raw_i),     .press_o(w_ev_uart));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step  (.clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_step_raw_i),     .press_o(w_ev_step));

    // Fixed-priority arbitration; losers are dropped
    logic w_win_uart, w_win_rst, w_win_err, w_win_pause, w_win_cont;
    logic w_btn_any, w_step_ev;

    always_comb begin
        w_win_uart  = w_ev_uart;
        w_win_rst   = w_ev_rst   & ~w_ev_uart;
        w_win_err   = w_ev_err   & ~(w_ev_uart | w_ev_rst);
        w_win_pause = w_ev_pause & ~(w_ev_uart | w_ev_rst | w_ev_err);
        w_win_cont  = w_ev_cont  & ~(w_ev_uart | w_ev_rst | w_ev_err | w_ev_pause);
        w_btn_any   = w_ev_uart | w_ev_rst | w_ev_err | w_ev_pause | w_ev_cont;
        w_step_ev   = w_ev_step & ~w_btn_any;
    end

    // Step sequencer
    step_state_e r_state, w_state_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic        w_fsm_cont, w_fsm_pause;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fsm_cont   = 1'b0;
        w_fsm_pause  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_step_ev && mode_i == MODE_PAUSE) w_state_next = ST_GO;
            end
            ST_GO: begin
                w_fsm_cont   = 1'b1;
                w_cnt_next   = '0;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter doubles as the RUN-arrival timeout here
                if (mode_i == MODE_RUN) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_RUN;
                end else if (r_cnt == STEP_WAIT_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            ST_RUN: begin
                if (mode_i != MODE_RUN) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_step_last) begin
                    w_state_next = ST_STOP;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                w_fsm_pause  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        // A real button press always pre-empts the sequencer and its pulse
        if (w_btn_any) begin
            w_state_next = ST_IDLE;
            w_fsm_cont   = 1'b0;
            w_fsm_pause  = 1'b0;
        end
    end

    logic       r_btn_rst, r_btn_err, r_btn_pause, r_btn_cont, r_btn_uart;
    logic       r_busy;
    logic [3:0] r_exc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_btn_rst   <= 1'b0;
            r_btn_err   <= 1'b0;
            r_btn_pause <= 1'b0;
            r_btn_cont  <= 1'b0;
            r_btn_uart  <= 1'b0;
            r_busy      <= 1'b0;
            r_exc       <= EXC_NONE;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_btn_rst   <= w_win_rst;
            r_btn_err   <= w_win_err;
            r_btn_pause <= w_win_pause | w_fsm_pause;
            r_btn_cont  <= w_win_cont  | w_fsm_cont;
            r_btn_uart  <= w_win_uart;
            // Registered from the state so it lines up with the request
            // pulses, which are also one register behind the FSM
            r_busy      <= (r_state != ST_IDLE);
            r_exc       <= exc_code_i;
        end
    end

    assign btn_rst_o      = r_btn_rst;
    assign btn_err_o      = r_btn_err;
    assign btn_pause_o    = r_btn_pause;
    assign btn_continue_o = r_btn_cont;
    assign btn_uart_o     = r_btn_uart;
    assign step_busy_o    = r_busy;
    assign exc_code_o     = r_exc;

endmodule
`default_nettype wire

// File: tb/tb_mode_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_req_sched
// Description : Directed self-checking bench for mode_req_sched with
//               DEB_CYCLES=4 and STEP_CYCLES=3. Inputs change on the falling
//               edge, outputs are sampled on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mode_req_sched;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rst_raw = 1'b0, err_raw = 1'b0, pause_raw = 1'b0;
    logic       cont_raw = 1'b0, uart_raw = 1'b0, step_raw = 1'b0;
    logic [3:0] mode = 4'd4;
    logic [3:0] exc_in = 4'd0;
    logic       btn_rst_o, btn_err_o, btn_pause_o, btn_continue_o, btn_uart_o;
    logic [3:0] exc_code_o;
    logic       step_busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mode_req_sched #(.DEB_CYCLES(4), .STEP_CYCLES(3)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .btn_rst_raw_i(rst_raw), .btn_err_raw_i(err_raw),
        .btn_pause_raw_i(pause_raw), .btn_continue_raw_i(cont_raw),
        .btn_uart_raw_i(uart_raw), .btn_step_raw_i(step_raw),
        .mode_i(mode), .exc_code_i(exc_in),
        .btn_rst_o(btn_rst_o), .btn_err_o(btn_err_o), .btn_pause_o(btn_pause_o),
        .btn_continue_o(btn_continue_o), .btn_uart_o(btn_uart_o),
        .exc_code_o(exc_code_o), .step_busy_o(step_busy_o)
    );

    // One request at a time, checked every cycle outside reset
    always @(negedge clk) begin
        if (!rst_i) begin
            n_cmp++;
            if ($countones({btn_rst_o, btn_err_o, btn_pause_o, btn_continue_o, btn_uart_o}) > 1) begin
                n_bad++;
                $display("FAIL onehot: outputs=%b required at most one set",
                         {btn_rst_o, btn_err_o, btn_pause_o, btn_continue_o, btn_uart_o});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        rst_raw = 0; err_raw = 0; pause_raw = 0; cont_raw = 0; uart_raw = 0; step_raw = 0;
        mode = 4'd4;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({btn_rst_o, btn_err_o, btn_pause_o, btn_continue_o, btn_uart_o, step_busy_o, exc_code_o} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 0",
                     {btn_rst_o, btn_err_o, btn_pause_o, btn_continue_o, btn_uart_o, step_busy_o, exc_code_o});
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_exc_passthrough();
        exc_in = 4'd5;
        n_cmp++;
        if (exc_code_o !== 4'd0) begin
            n_bad++; $display("FAIL exc_before: got %0d required 0", exc_code_o);
        end
        tick();
        n_cmp++;
        if (exc_code_o !== 4'd5) begin
            n_bad++; $display("FAIL exc_delay: got %0d required 5", exc_code_o);
        end
        exc_in = 4'd9;
        tick();
        n_cmp++;
        if (exc_code_o !== 4'd9) begin
            n_bad++; $display("FAIL exc_nofilter: got %0d required 9", exc_code_o);
        end
        exc_in = 4'd0;
        tick();
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int first = 0;
        for (int i = 0; i < 5; i++) begin
            pause_raw = 1; tick(); if (btn_pause_o) pulses++; tick(); if (btn_pause_o) pulses++;
            pause_raw = 0; tick(); if (btn_pause_o) pulses++; tick(); if (btn_pause_o) pulses++;
        end
        pause_raw = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (btn_pause_o) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++; $display("FAIL bounce_count: got %0d pulses required 1", pulses);
        end
        n_cmp++;
        if (first !== 8) begin
            n_bad++; $display("FAIL bounce_latency: got %0d cycles required 8", first);
        end
        settle();
    endtask

    task automatic test_simultaneous();
        int n_uart = 0;
        int n_rst = 0;
        int first = 0;
        uart_raw = 1; rst_raw = 1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (btn_uart_o) begin n_uart++; if (first == 0) first = c; end
            if (btn_rst_o) n_rst++;
        end
        n_cmp++;
        if (n_uart !== 1) begin
            n_bad++; $display("FAIL simul_uart: got %0d pulses required 1", n_uart);
        end
        n_cmp++;
        if (n_rst !== 0) begin
            n_bad++; $display("FAIL simul_rst: got %0d pulses required 0", n_rst);
        end
        n_cmp++;
        if (first !== 8) begin
            n_bad++; $display("FAIL simul_latency: got %0d cycles required 8", first);
        end
        settle();
    endtask

    task automatic test_single_step();
        int first_cont = 0;
        int first_pause = 0;
        int busy_fall = 0;
        int n_cont = 0;
        mode = 4'd4;
        step_raw = 1;
        for (int c = 1; c <= 20 && first_cont == 0; c++) begin
            tick();
            if (btn_continue_o) first_cont = c;
        end
        n_cmp++;
        if (first_cont !== 9) begin
            n_bad++; $display("FAIL step_continue: got cycle %0d required 9", first_cont);
        end
        n_cmp++;
        if (step_busy_o !== 1'b1) begin
            n_bad++; $display("FAIL step_busy_rise: got %b required 1", step_busy_o);
        end
        tick(); tick();
        mode = 4'd5;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (btn_pause_o && first_pause == 0) first_pause = c;
            if (btn_continue_o) n_cont++;
            if (!step_busy_o && busy_fall == 0) busy_fall = c;
        end
        n_cmp++;
        if (first_pause !== 5) begin
            n_bad++; $display("FAIL step_pause: got cycle %0d required 5", first_pause);
        end
        n_cmp++;
        if (busy_fall !== 6) begin
            n_bad++; $display("FAIL step_busy_fall: got cycle %0d required 6", busy_fall);
        end
        n_cmp++;
        if (n_cont !== 0) begin
            n_bad++; $display("FAIL step_extra_continue: got %0d required 0", n_cont);
        end
        settle();
    endtask

    task automatic test_step_ignored();
        int n_out = 0;
        int n_busy = 0;
        mode = 4'd5;
        step_raw = 1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (btn_rst_o | btn_err_o | btn_pause_o | btn_continue_o | btn_uart_o) n_out++;
            if (step_busy_o) n_busy++;
        end
        n_cmp++;
        if (n_out !== 0) begin
            n_bad++; $display("FAIL ignored_pulses: got %0d required 0", n_out);
        end
        n_cmp++;
        if (n_busy !== 0) begin
            n_bad++; $display("FAIL ignored_busy: got %0d busy cycles required 0", n_busy);
        end
        settle();
    endtask

    task automatic test_preempt_err();
        int first_cont = 0;
        int first_err = 0;
        int n_err_p = 0;
        int n_pause = 0;
        mode = 4'd4;
        step_raw = 1;
        repeat (4) tick();
        // Timed so the err press lands while the sequencer is in RUN
        err_raw = 1;
        for (int c = 5; c <= 20 && first_cont == 0; c++) begin
            tick();
            if (btn_continue_o) first_cont = c;
        end
        n_cmp++;
        if (first_cont !== 9) begin
            n_bad++; $display("FAIL preempt_continue: got cycle %0d required 9", first_cont);
        end
        mode = 4'd5;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (btn_err_o) begin n_err_p++; if (first_err == 0) first_err = c; end
            if (btn_pause_o) n_pause++;
        end
        n_cmp++;
        if (n_err_p !== 1 || first_err !== 3) begin
            n_bad++; $display("FAIL preempt_err: got %0d pulses at cycle %0d required 1 at 3", n_err_p, first_err);
        end
        n_cmp++;
        if (n_pause !== 0) begin
            n_bad++; $display("FAIL preempt_pause: got %0d required 0", n_pause);
        end
        n_cmp++;
        if (step_busy_o !== 1'b0) begin
            n_bad++; $display("FAIL preempt_busy: got %b required 0", step_busy_o);
        end
        settle();
    endtask

    task automatic test_abort_mode();
        int first_cont = 0;
        int n_pulse = 0;
        mode = 4'd4;
        step_raw = 1;
        for (int c = 1; c <= 20 && first_cont == 0; c++) begin
            tick();
            if (btn_continue_o) first_cont = c;
        end
        mode = 4'd5;
        tick(); tick();
        n_cmp++;
        if (step_busy_o !== 1'b1) begin
            n_bad++; $display("FAIL abort_busy_before: got %b required 1", step_busy_o);
        end
        mode = 4'd6;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (btn_pause_o | btn_continue_o) n_pulse++;
        end
        n_cmp++;
        if (n_pulse !== 0) begin
            n_bad++; $display("FAIL abort_pulses: got %0d required 0", n_pulse);
        end
        n_cmp++;
        if (step_busy_o !== 1'b0) begin
            n_bad++; $display("FAIL abort_busy_after: got %b required 0", step_busy_o);
        end
        settle();
    endtask

    task automatic test_reset_mid_run();
        int first_cont = 0;
        mode = 4'd4;
        step_raw = 1;
        for (int c = 1; c <= 20 && first_cont == 0; c++) begin
            tick();
            if (btn_continue_o) first_cont = c;
        end
        mode = 4'd5;
        exc_in = 4'd7;
        tick(); tick();
        rst_i = 1'b1;
        tick();
        n_cmp++;
        if ({btn_rst_o, btn_err_o, btn_pause_o, btn_continue_o, btn_uart_o, step_busy_o, exc_code_o} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_mid_run: got %b required 0",
                     {btn_rst_o, btn_err_o, btn_pause_o, btn_continue_o, btn_uart_o, step_busy_o, exc_code_o});
        end
        rst_i = 1'b0;
        exc_in = 4'd0;
        settle();
    endtask

    initial begin
        settle_init: begin
            @(negedge clk);
        end
        test_reset();
        test_exc_passthrough();
        test_bounce();
        test_simultaneous();
        test_single_step();
        test_step_ignored();
        test_preempt_err();
        test_abort_mode();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
